// File: rtl/fir_filter_mac.sv
// -----------------------------------------------------------------------------
// fir_filter_mac
//
// Time-multiplexed FIR filter with a single multiplier. A rising edge on
// newData captures one sample into a circular delay line. The block then
// spends TAPS cycles accumulating one tap per clock, and spends one more
// cycle rounding, reducing and registering the result. Coefficients live in
// a run-time-writable bank. After reset the bank holds unity passthrough:
// coef[0] = 2^SHIFT and every other coefficient is 0.
//
// Optional feature (compile-time macro):
//   FIR_SATURATE_EN  defined   : result clamps to the DATA_W signed range and
//                                satFlag marks a clamp.
//                    undefined : result wraps to its low DATA_W bits and
//                                satFlag stays 0.
//
// Ports:
//   clk         in   rising-edge clock for all logic
//   rst         in   synchronous, active-high reset (also aborts a computation)
//   inSignal    in   DATA_W signed input sample
//   newData     in   sample strobe; only its rising edge starts a computation
//   coefWe      in   coefficient write enable, honoured only while idle
//   coefAddr    in   coefficient index k
//   coefData    in   COEF_W signed coefficient value
//   clrOverrun  in   clears the sticky overrun flag
//   outSignal   out  DATA_W filtered sample, held between dataReady pulses
//   dataReady   out  one-cycle pulse when outSignal updates
//   busy        out  high while a computation is in flight
//   overrun     out  sticky: a start arrived while busy and was dropped
//   satFlag     out  result was clipped; valid with dataReady
// -----------------------------------------------------------------------------
module fir_filter_mac #(
  parameter int DATA_W = 18,
  parameter int COEF_W = 18,
  parameter int TAPS   = 16,
  parameter int SHIFT  = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] inSignal,
  input  logic                     newData,
  input  logic                     coefWe,
  input  logic [$clog2(TAPS)-1:0]  coefAddr,
  input  logic signed [COEF_W-1:0] coefData,
  input  logic                     clrOverrun,
  output logic signed [DATA_W-1:0] outSignal,
  output logic                     dataReady,
  output logic                     busy,
  output logic                     overrun,
  output logic                     satFlag
);

  localparam int AW       = $clog2(TAPS);
  localparam int PROD_W   = DATA_W + COEF_W;
  // One guard bit per doubling of the tap count keeps the sum from overflowing.
  localparam int ACC_W    = PROD_W + AW;
  localparam int SCALED_W = ACC_W - SHIFT;

  localparam logic [AW-1:0]            LAST_K     = AW'(TAPS - 1);
  localparam logic [AW:0]              TAPS_X     = (AW + 1)'(TAPS);
  localparam logic signed [COEF_W-1:0] UNITY      = COEF_W'(1) << SHIFT;
  localparam logic signed [ACC_W-1:0]  ROUND_HALF = ACC_W'(1) << (SHIFT - 1);

  if (TAPS < 2) begin : gTapsCheck
    $error("fir_filter_mac: TAPS must be at least 2");
  end
  if (SHIFT < 1 || SHIFT > COEF_W - 2) begin : gShiftCheck
    $error("fir_filter_mac: SHIFT must lie in 1..COEF_W-2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } stateType;

  stateType state;
  stateType nextState;

  logic                     newDataPrev;
  logic                     start;
  logic signed [DATA_W-1:0] xLine [TAPS];
  logic signed [COEF_W-1:0] coef  [TAPS];
  logic [AW-1:0]            wrPtr;
  logic [AW-1:0]            base;
  logic [AW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;
  logic                     addrOk;

  // Start is the rising edge of newData. A strobe that stays high therefore
  // launches exactly one computation.
  assign start  = newData & ~newDataPrev;
  assign addrOk = ({1'b0, coefAddr} < TAPS_X);

  // ---------------------------------------------------------------------------
  // Tap addressing: x[(base - k) mod TAPS]. This form also works when TAPS is
  // not a power of two, because the wrap is explicit rather than relying on
  // pointer overflow.
  // ---------------------------------------------------------------------------
  logic [AW:0]   idxSum;
  logic [AW:0]   idxWrap;
  logic [AW-1:0] tapIdx;

  assign idxSum  = {1'b0, base} + TAPS_X - {1'b0, k};
  assign idxWrap = (idxSum >= TAPS_X) ? idxSum - TAPS_X : idxSum;
  assign tapIdx  = idxWrap[AW-1:0];

  logic signed [PROD_W-1:0] product;
  assign product = PROD_W'(coef[k]) * PROD_W'(xLine[tapIdx]);

  // ---------------------------------------------------------------------------
  // Output scaling: add one half LSB, then take the arithmetic shift as a
  // slice. Taking the slice of a signed value equals >>> SHIFT (round half up).
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0]    roundedAcc;
  logic signed [SCALED_W-1:0] scaled;
  logic signed [DATA_W-1:0]   resultD;
  logic                       satD;
  logic                       unusedBits;

  assign roundedAcc = acc + ROUND_HALF;
  assign scaled     = roundedAcc[ACC_W-1:SHIFT];

`ifdef FIR_SATURATE_EN
  localparam logic signed [DATA_W-1:0] MAX_OUT = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_OUT = {1'b1, {(DATA_W-1){1'b0}}};

  // The value fits in DATA_W bits when every bit above the output sign bit
  // equals the sign bit.
  logic fits;
  assign fits = (scaled[SCALED_W-1:DATA_W-1] ==
                 {(SCALED_W-DATA_W+1){scaled[SCALED_W-1]}});

  always_comb begin
    resultD = scaled[DATA_W-1:0];
    satD    = 1'b0;
    if (!fits) begin
      satD    = 1'b1;
      resultD = scaled[SCALED_W-1] ? MIN_OUT : MAX_OUT;
    end
  end

  assign unusedBits = ^{roundedAcc[SHIFT-1:0], idxWrap[AW]};
`else
  assign resultD    = scaled[DATA_W-1:0];
  assign satD       = 1'b0;
  assign unusedBits = ^{roundedAcc[SHIFT-1:0], scaled[SCALED_W-1:DATA_W],
                        idxWrap[AW]};
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the values
    // it saw before the edge, whatever the statement order.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    nextState = state;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:    if (start) nextState = MAC;
      MAC:     if (k == LAST_K) nextState = OUT;
      OUT:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath, coefficient bank and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both arrays are reset on purpose. The coefficients must return
      // to unity passthrough and the delay line to zero, so they are built as
      // flops rather than as a RAM.
      for (int i = 0; i < TAPS; i++) begin
        xLine[i] <= '0;
        coef[i]  <= (i == 0) ? UNITY : '0;
      end
      newDataPrev <= 1'b0;
      wrPtr       <= '0;
      base        <= '0;
      k           <= '0;
      acc         <= '0;
      outSignal   <= '0;
      dataReady   <= 1'b0;
      overrun     <= 1'b0;
      satFlag     <= 1'b0;
    end else begin
      newDataPrev <= newData;
      dataReady   <= 1'b0;

      // The first MAC cycle reads the bank after this edge. A write issued in
      // the same cycle as a start is therefore seen by that computation.
      if (coefWe && (state == IDLE) && addrOk) begin
        coef[coefAddr] <= coefData;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            xLine[wrPtr] <= inSignal;
            base         <= wrPtr;
            wrPtr        <= (wrPtr == LAST_K) ? '0 : wrPtr + 1'b1;
            acc          <= '0;
            k            <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(product);
          k   <= (k == LAST_K) ? '0 : k + 1'b1;
        end
        OUT: begin
          outSignal <= resultD;
          satFlag   <= satD;
          dataReady <= 1'b1;
        end
        default: ;
      endcase

      // If a drop and a clear occur in the same cycle, the drop wins.
      if (start && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clrOverrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_mac.sv
// -----------------------------------------------------------------------------
// tb_fir_filter_mac
//
// Bench for fir_filter_mac at default parameters. A reference model follows
// the block's observable behaviour:
//   - which strobes are accepted,
//   - the latency to each result,
//   - the filtered value, computed as a plain convolution over a sample
//     history.
// A compare process checks the DUT against the model on every falling edge.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fir_filter_mac;

  localparam int DATA_W = 18;
  localparam int COEF_W = 18;
  localparam int TAPS   = 16;
  localparam int SHIFT  = 12;
  localparam int AW     = $clog2(TAPS);

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] inSignal;
  logic              newData;
  logic              coefWe;
  logic [AW-1:0]     coefAddr;
  logic [COEF_W-1:0] coefData;
  logic              clrOverrun;
  logic [DATA_W-1:0] outSignal;
  logic              dataReady;
  logic              busy;
  logic              overrun;
  logic              satFlag;

  fir_filter_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .SHIFT  (SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inSignal   (inSignal),
    .newData    (newData),
    .coefWe     (coefWe),
    .coefAddr   (coefAddr),
    .coefData   (coefData),
    .clrOverrun (clrOverrun),
    .outSignal  (outSignal),
    .dataReady  (dataReady),
    .busy       (busy),
    .overrun    (overrun),
    .satFlag    (satFlag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, updated on each rising edge from the inputs it samples.
  // ---------------------------------------------------------------------------
  longint            mCoef [TAPS];
  longint            hist  [TAPS];   // hist[0] is the newest accepted sample
  int                edgeNo    = 0;
  int                startEdge = 0;
  bit                active    = 1'b0;
  bit                mOverrun  = 1'b0;
  bit                prevNd    = 1'b0;
  logic [DATA_W-1:0] mOut      = '0;
  logic [DATA_W-1:0] pendOut   = '0;
  bit                mSat      = 1'b0;
  bit                pendSat   = 1'b0;

  always @(posedge clk) begin
    bit     idleNow;
    bit     startEv;
    longint y;
    edgeNo++;
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        mCoef[i] = (i == 0) ? (longint'(1) << SHIFT) : 0;
        hist[i]  = 0;
      end
      active   = 1'b0;
      mOverrun = 1'b0;
      prevNd   = 1'b0;
      mOut     = '0;
      mSat     = 1'b0;
    end else begin
      if (active && edgeNo == startEdge + TAPS + 1) begin
        mOut = pendOut;
        mSat = pendSat;
      end
      idleNow = !active || (edgeNo >= startEdge + TAPS + 2);
      if (idleNow) active = 1'b0;
      startEv = newData && !prevNd;
      if (coefWe && idleNow && int'(coefAddr) < TAPS) begin
        mCoef[coefAddr] = longint'($signed(coefData));
      end
      if (startEv && idleNow) begin
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = longint'($signed(inSignal));
        y = 0;
        for (int i = 0; i < TAPS; i++) y += mCoef[i] * hist[i];
        y = (y + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`ifdef FIR_SATURATE_EN
        if (y > 131071) begin
          pendOut = 18'h1FFFF;
          pendSat = 1'b1;
        end else if (y < -131072) begin
          pendOut = 18'h20000;
          pendSat = 1'b1;
        end else begin
          pendOut = y[DATA_W-1:0];
          pendSat = 1'b0;
        end
`else
        pendOut = y[DATA_W-1:0];
        pendSat = 1'b0;
`endif
        startEdge = edgeNo;
        active    = 1'b1;
      end
      if (startEv && !idleNow) mOverrun = 1'b1;
      else if (clrOverrun)     mOverrun = 1'b0;
      prevNd = newData;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: checks every falling edge once reset has been applied.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    bit expReady;
    bit expBusy;
    if (checkEn) begin
      expReady = active && (edgeNo == startEdge + TAPS + 1);
      expBusy  = active && (edgeNo <= startEdge + TAPS);
      check("cmp dataReady", dataReady, expReady);
      check("cmp busy", busy, expBusy);
      check("cmp overrun", overrun, mOverrun);
      check("cmp outSignal", outSignal, mOut);
      if (expReady) check("cmp satFlag", satFlag, mSat);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic writeCoef(input int addr, input logic [COEF_W-1:0] val);
    coefWe   = 1'b1;
    coefAddr = AW'(addr);
    coefData = val;
    @(negedge clk);
    coefWe   = 1'b0;
  endtask

  task automatic sendSample(input logic [DATA_W-1:0] val);
    inSignal = val;
    newData  = 1'b1;
    @(negedge clk);
    newData  = 1'b0;
  endtask

  task automatic getReady(input string name, input logic [DATA_W-1:0] expVal,
                          input bit chkSat, input bit expSat);
    bit seen = 1'b0;
    int i    = 0;
    while (!seen && i < 40) begin
      @(negedge clk);
      i++;
      if (dataReady) seen = 1'b1;
    end
    check({name, " ready seen"}, seen, 1'b1);
    if (seen) begin
      check(name, outSignal, expVal);
      if (chkSat) check({name, " satFlag"}, satFlag, expSat);
    end
  endtask

  task automatic countPulses(input int cycles, output int n,
                             output logic [DATA_W-1:0] lastVal);
    n       = 0;
    lastVal = '0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dataReady) begin
        n++;
        lastVal = outSignal;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int                n;
    int                p;
    logic [DATA_W-1:0] v;
    bit                seen;

    rst        = 1'b1;
    inSignal   = '0;
    newData    = 1'b0;
    coefWe     = 1'b0;
    coefAddr   = '0;
    coefData   = '0;
    clrOverrun = 1'b0;
    @(negedge clk);
    checkEn = 1'b1;
    check("reset outSignal", outSignal, 18'h00000);
    check("reset dataReady", dataReady, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset overrun", overrun, 1'b0);
    check("reset satFlag", satFlag, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Passthrough with newData held high: one pulse at E17, then silence.
    doReset();
    inSignal = 18'h00800;
    newData  = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (dataReady) seen = 1'b1;
    end
    check("pass latency", n, 18);
    check("pass out", outSignal, 18'h00800);
    countPulses(30, p, v);
    check("pass single pulse", p, 0);
    newData = 1'b0;
    @(negedge clk);

    // Impulse response with coef[k] = 4096*(k+1).
    doReset();
    for (int kk = 0; kk < TAPS; kk++) writeCoef(kk, COEF_W'(4096 * (kk + 1)));
    for (int s = 0; s < TAPS; s++) begin
      sendSample((s == 0) ? 18'h00001 : 18'h00000);
      getReady("impulse", DATA_W'(s + 1), 1'b0, 1'b0);
    end
    check("impulse overrun", overrun, 1'b0);

    // Saturation (or wrap) with coef[0] = 4.0.
    doReset();
    writeCoef(0, 18'h04000);
    sendSample(18'h10000);
`ifdef FIR_SATURATE_EN
    getReady("sat pos", 18'h1FFFF, 1'b1, 1'b1);
    sendSample(18'h20000);
    getReady("sat neg", 18'h20000, 1'b1, 1'b1);
`else
    getReady("wrap pos", 18'h00000, 1'b1, 1'b0);
    sendSample(18'h20000);
    getReady("wrap neg", 18'h00000, 1'b1, 1'b0);
`endif

    // Rounding with coef[0] = 0.5.
    doReset();
    writeCoef(0, 18'h00800);
    sendSample(18'h00003);
    getReady("round +3", 18'h00002, 1'b0, 1'b0);
    sendSample(18'h3FFFD);
    getReady("round -3", 18'h3FFFF, 1'b0, 1'b0);

    // Overrun and coefficient lockout: second edge at E5, write at E6.
    doReset();
    inSignal = 18'h00100;
    newData  = 1'b1;
    @(negedge clk);                       // after E0
    newData  = 1'b0;
    repeat (4) @(negedge clk);            // after E4
    newData  = 1'b1;
    @(negedge clk);                       // after E5
    newData  = 1'b0;
    coefWe   = 1'b1;
    coefAddr = '0;
    coefData = 18'd12345;
    @(negedge clk);                       // after E6
    coefWe   = 1'b0;
    countPulses(25, p, v);
    check("ovr pulses", p, 1);
    check("ovr out", v, 18'h00100);
    check("ovr flag set", overrun, 1'b1);
    sendSample(18'h00200);
    getReady("ovr coef kept", 18'h00200, 1'b0, 1'b0);
    clrOverrun = 1'b1;
    @(negedge clk);
    clrOverrun = 1'b0;
    check("ovr cleared", overrun, 1'b0);

    // Reset in mid-computation, with altered coefficients and overrun set.
    doReset();
    writeCoef(0, 18'h00800);
    writeCoef(1, 18'h01000);
    sendSample(18'h00800);
    getReady("mid pre", 18'h00400, 1'b0, 1'b0);
    inSignal = 18'h00100;
    newData  = 1'b1;
    @(negedge clk);                       // after E0
    newData  = 1'b0;
    @(negedge clk);                       // after E1
    @(negedge clk);                       // after E2
    newData  = 1'b1;
    @(negedge clk);                       // after E3
    newData  = 1'b0;
    repeat (4) @(negedge clk);            // after E7
    check("mid overrun before rst", overrun, 1'b1);
    rst = 1'b1;
    @(negedge clk);                       // after E8
    rst = 1'b0;
    check("mid busy", busy, 1'b0);
    check("mid outSignal", outSignal, 18'h00000);
    check("mid overrun", overrun, 1'b0);
    countPulses(25, p, v);
    check("mid no pulse", p, 0);
    sendSample(18'h00800);
    getReady("mid restored", 18'h00800, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog");
  end

endmodule
